fc_layer_seq: RTL and testbench
===============================

Name: fc_layer_seq

Overview:
Parametrised sequential fully-connected layer for the MLP datapath. It holds OUTPUT_NODES signed multiply-accumulate lanes internally. One input element is broadcast per cycle while the block drives the address of a synchronous weight ROM; after the last element it adds per-node bias, rescales, applies optional ReLU and saturates. A start/busy/done handshake lets layers be chained by a top-level sequencer.

Parameters:
DATA_WIDTH, 8, width of each activation, weight, bias and output element (signed two's complement, fixed point)
INPUT_NODES, 24, number of input elements (fan-in)
OUTPUT_NODES, 128, number of neurons / MAC lanes
ADDR_WIDTH, 5, width of weight_address; 2^ADDR_WIDTH >= INPUT_NODES required
ACC_WIDTH, 24, accumulator width; must be >= 2*DATA_WIDTH + ceil(log2(INPUT_NODES)) + 1
FRAC_BITS, 4, fractional bits of the shared Q format for activations, weights and bias
RELU_EN, 1, 1 = clamp negative results to 0 before saturation; 0 = linear output

Ports:
clk  input  1  single clock, all logic on rising edge
reset  input  1  synchronous, active-high
start  input  1  request to process input_fc; sampled only in IDLE
input_fc  input  DATA_WIDTH*INPUT_NODES  element j at [DATA_WIDTH*j +: DATA_WIDTH]; captured on the accepting edge
weight_address  output  ADDR_WIDTH  ROM row index = input element index
weights  input  DATA_WIDTH*OUTPUT_NODES  ROM row; lane i at [DATA_WIDTH*i +: DATA_WIDTH]; valid one cycle after weight_address
bias  input  DATA_WIDTH*OUTPUT_NODES  per-node bias, same Q format; sampled in FINISH
busy  output  1  high from accepting edge until done edge
done  output  1  one-cycle pulse when output_fc updates
output_fc  output  DATA_WIDTH*OUTPUT_NODES  registered results; lane i at [DATA_WIDTH*i +: DATA_WIDTH]; held until next done

Behaviour:
- Reset (sync): state IDLE; weight_address=0, busy=0, done=0, output_fc=0, accumulators=0, input register=0. Reset in any state aborts the operation; no done is produced.
- States: IDLE, RUN, DRAIN, FINISH.
- IDLE: weight_address=0. start=1 at edge E0 -> capture input_fc, clear all accumulators, busy=1, cnt=0, go to RUN.
- RUN: weight_address=cnt; cnt increments each edge. After the edge where cnt=INPUT_NODES-1 is issued, go to DRAIN.
- MAC pipeline: in the cycle after address k is issued, each lane i does acc_i += sext(x_k * w_i,k). The product is signed 2*DATA_WIDTH, sign-extended to ACC_WIDTH. This applies to the RUN cycles after the first and to the DRAIN cycle.
- DRAIN: performs the last MAC (k=INPUT_NODES-1); weight_address holds INPUT_NODES-1; go to FINISH.
- FINISH: computes the result for each lane i:
  - r = (acc_i + (sext(bias_i) <<< FRAC_BITS)) >>> FRAC_BITS (arithmetic shift, floor).
  - If RELU_EN and r<0, then r=0.
  - Saturate r to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - Register r into output_fc, done=1 for this edge only, busy=0, go to IDLE.
- Latency: done and new output_fc appear at the edge INPUT_NODES+2 edges after E0. Minimum start-to-start interval is INPUT_NODES+3 cycles.
- start while busy (including the FINISH cycle) is ignored, not queued. input_fc changes after E0 have no effect on the current operation.
- Accumulator never overflows given the ACC_WIDTH constraint; no wrap handling is required.

Test Plan:
- INPUT_NODES=4, OUTPUT_NODES=2, FRAC_BITS=0, RELU_EN=1, x=[1,2,3,4], w0=[1,1,1,1], w1=[1,-1,1,-1], bias=0 -> output_fc lane0=10, lane1=0 (ReLU); with RELU_EN=0, lane1=0xFE (-2).
- Timing, same config, start pulse at E0 -> weight_address 0,1,2,3 on consecutive cycles; busy high E0..E5; done exactly one cycle at E6; a second start at E3 is ignored (no extra done).
- Saturation, FRAC_BITS=0, RELU_EN=0: all x=127, all w=127 -> 0x7F; all x=127, all w=-128 -> 0x80.
- Fixed point, FRAC_BITS=4: x all 0x10 (1.0), w all 0x08 (0.5), bias 0x08 (0.5) -> every lane 0x28 (2.5).
- Reset asserted at E2 mid-RUN -> next edge busy=0, done=0, output_fc=0, weight_address=0. A fresh start then completes normally with correct values, proving accumulators were cleared.
- Back-to-back: start held high continuously -> operations accepted every INPUT_NODES+3 cycles, each result matching its captured input_fc.

Source files
------------

// File: rtl/fc_layer_seq.sv
// fc_layer_seq: sequential fully-connected layer.
// One input element per cycle into OUTPUT_NODES signed MAC lanes.
module fc_layer_seq #(
  parameter int DATA_WIDTH   = 8,
  parameter int INPUT_NODES  = 24,
  parameter int OUTPUT_NODES = 128,
  parameter int ADDR_WIDTH   = 5,
  parameter int ACC_WIDTH    = 24,
  parameter int FRAC_BITS    = 4,
  parameter int RELU_EN      = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [DATA_WIDTH*INPUT_NODES-1:0]  input_fc,
  output logic [ADDR_WIDTH-1:0]              weight_address,
  input  logic [DATA_WIDTH*OUTPUT_NODES-1:0] weights,
  input  logic [DATA_WIDTH*OUTPUT_NODES-1:0] bias,
  output logic                               busy,
  output logic                               done,
  output logic [DATA_WIDTH*OUTPUT_NODES-1:0] output_fc
);

  localparam int DW = DATA_WIDTH;
  localparam int PW = 2 * DATA_WIDTH;
  localparam int SW = ACC_WIDTH + 2;

  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(INPUT_NODES - 1);

  localparam logic signed [SW-1:0] MAXV =
    SW'((2 ** (DW - 1)) - 1);
  localparam logic signed [SW-1:0] MINV =
    -MAXV - SW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_FINISH
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  done_q, done_d;

  logic load;
  logic mac_en;
  logic fin;

  logic [DATA_WIDTH*INPUT_NODES-1:0]  x_q;
  logic [DATA_WIDTH*OUTPUT_NODES-1:0] out_q;

  logic signed [ACC_WIDTH-1:0] acc_q [OUTPUT_NODES];

  int                   k_idx;
  logic signed [DW-1:0] x_k;

  logic signed [DW-1:0] w_l   [OUTPUT_NODES];
  logic signed [DW-1:0] b_l   [OUTPUT_NODES];
  logic signed [PW-1:0] prod  [OUTPUT_NODES];
  logic signed [SW-1:0] sum_l [OUTPUT_NODES];
  logic signed [SW-1:0] shf_l [OUTPUT_NODES];
  logic signed [DW-1:0] res   [OUTPUT_NODES];

  assign weight_address = addr_q;
  assign busy           = (state_q != S_IDLE);
  assign done           = done_q;
  assign output_fc      = out_q;

  // Next-state, address sequencing and datapath strobes
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    done_d  = 1'b0;
    load    = 1'b0;
    mac_en  = 1'b0;
    fin     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        addr_d = '0;
        if (start) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        mac_en = (cnt_q != '0);
        if (cnt_q == LAST) begin
          addr_d  = LAST;
          state_d = S_DRAIN;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          addr_d = cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        mac_en  = 1'b1;
        addr_d  = LAST;
        state_d = S_FINISH;
      end
      S_FINISH: begin
        fin     = 1'b1;
        done_d  = 1'b1;
        addr_d  = '0;
        state_d = S_IDLE;
      end
      default: begin
        addr_d  = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Pick the input element whose weight row is on the ROM bus
  always_comb begin
    k_idx = INPUT_NODES - 1;
    if (state_q == S_RUN && cnt_q != '0) begin
      k_idx = int'(cnt_q) - 1;
    end
    x_k = x_q[DW*k_idx +: DW];
  end

  // Per-lane product and bias/rescale/ReLU/saturate result
  always_comb begin
    for (int i = 0; i < OUTPUT_NODES; i++) begin
      w_l[i]   = $signed(weights[DW*i +: DW]);
      b_l[i]   = $signed(bias[DW*i +: DW]);
      prod[i]  = PW'(x_k) * PW'(w_l[i]);
      sum_l[i] = SW'(acc_q[i]) + (SW'(b_l[i]) <<< FRAC_BITS);
      shf_l[i] = sum_l[i] >>> FRAC_BITS;
      if (RELU_EN != 0 && shf_l[i] < 0) begin
        shf_l[i] = '0;
      end
      if (shf_l[i] > MAXV) begin
        res[i] = MAXV[DW-1:0];
      end else if (shf_l[i] < MINV) begin
        res[i] = MINV[DW-1:0];
      end else begin
        res[i] = shf_l[i][DW-1:0];
      end
    end
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
    end
  end

  // Input capture and accumulator lanes
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q <= '0;
      for (int i = 0; i < OUTPUT_NODES; i++) begin
        acc_q[i] <= '0;
      end
    end else if (load) begin
      x_q <= input_fc;
      for (int i = 0; i < OUTPUT_NODES; i++) begin
        acc_q[i] <= '0;
      end
    end else if (mac_en) begin
      for (int i = 0; i < OUTPUT_NODES; i++) begin
        acc_q[i] <= acc_q[i] + ACC_WIDTH'(prod[i]);
      end
    end
  end

  // Result register, updated only on the finishing edge
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= '0;
    end else if (fin) begin
      for (int i = 0; i < OUTPUT_NODES; i++) begin
        out_q[DW*i +: DW] <= res[i];
      end
    end
  end

endmodule

// File: tb/tb_fc_layer_seq.sv
// tb_fc_layer_seq: scoreboard bench for fc_layer_seq.
// Two instances: A (Q0, ReLU) and B (Q4, linear).
module tb_fc_layer_seq;

  localparam int DW = 8;
  localparam int IN = 4;
  localparam int ON = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [31:0]   input_fc;
  logic [31:0]   bias;
  logic [AW-1:0] addr_a, addr_b;
  logic [31:0]   w_a, w_b;
  logic          busy_a, busy_b;
  logic          done_a, done_b;
  logic [31:0]   out_a, out_b;

  logic [31:0] rom [IN];

  int xs [IN];
  int ws [IN][ON];
  int bs [ON];

  logic [31:0] qa [$];
  logic [31:0] qb [$];

  int n_tests = 0;
  int n_fail  = 0;
  int n_acc   = 0;
  int dones_a = 0;
  int dones_b = 0;

  always #5 clk = ~clk;

  fc_layer_seq #(
    .DATA_WIDTH(DW), .INPUT_NODES(IN), .OUTPUT_NODES(ON),
    .ADDR_WIDTH(AW), .ACC_WIDTH(24), .FRAC_BITS(0), .RELU_EN(1)
  ) u_a (
    .clk(clk), .reset(reset), .start(start),
    .input_fc(input_fc), .weight_address(addr_a),
    .weights(w_a), .bias(bias), .busy(busy_a),
    .done(done_a), .output_fc(out_a)
  );

  fc_layer_seq #(
    .DATA_WIDTH(DW), .INPUT_NODES(IN), .OUTPUT_NODES(ON),
    .ADDR_WIDTH(AW), .ACC_WIDTH(24), .FRAC_BITS(4), .RELU_EN(0)
  ) u_b (
    .clk(clk), .reset(reset), .start(start),
    .input_fc(input_fc), .weight_address(addr_b),
    .weights(w_b), .bias(bias), .busy(busy_b),
    .done(done_b), .output_fc(out_b)
  );

  // synchronous weight ROM, one row per address
  always @(posedge clk) begin
    w_a <= rom[addr_a];
    w_b <= rom[addr_b];
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reference: dot product, bias, floor rescale, ReLU, clamp
  function automatic logic [31:0] model(input int f, input int relu);
    logic [31:0] v;
    int acc, s, d, r;
    v = '0;
    d = 1 << f;
    for (int i = 0; i < ON; i++) begin
      acc = 0;
      for (int j = 0; j < IN; j++) acc += xs[j] * ws[j][i];
      s = acc + bs[i] * d;
      if (s >= 0) r = s / d;
      else        r = -((-s + d - 1) / d);
      if (relu != 0 && r < 0) r = 0;
      if (r > 127)  r = 127;
      if (r < -128) r = -128;
      v[8*i +: 8] = 8'(r);
    end
    return v;
  endfunction

  function automatic int rnd8();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  task automatic drive_x();
    for (int j = 0; j < IN; j++) input_fc[8*j +: 8] = 8'(xs[j]);
  endtask

  task automatic drive_wb();
    for (int j = 0; j < IN; j++)
      for (int i = 0; i < ON; i++)
        rom[j][8*i +: 8] = 8'(ws[j][i]);
    for (int i = 0; i < ON; i++) bias[8*i +: 8] = 8'(bs[i]);
  endtask

  task automatic rand_all();
    for (int j = 0; j < IN; j++) xs[j] = rnd8();
    for (int j = 0; j < IN; j++)
      for (int i = 0; i < ON; i++) ws[j][i] = rnd8();
    for (int i = 0; i < ON; i++) bs[i] = rnd8();
  endtask

  task automatic push_exp();
    qa.push_back(model(0, 1));
    qb.push_back(model(4, 0));
    n_acc++;
  endtask

  // one operation with cycle-level handshake checks
  task automatic run_op(input bit ign);
    int ea;
    drive_wb();
    drive_x();
    start = 1'b1;
    tick();
    push_exp();
    start = 1'b0;
    check("busy_e0", 32'(busy_a), 32'd1);
    check("addr_e0", 32'(addr_a), 32'd0);
    for (int e = 1; e <= 7; e++) begin
      start = (ign && e == 3);
      if (e == 1) input_fc = $urandom;
      tick();
      if (e <= 4) begin
        ea = (e > 3) ? 3 : e;
        check($sformatf("addr_e%0d", e), 32'(addr_a), 32'(ea));
        check($sformatf("addr_b_e%0d", e), 32'(addr_b), 32'(ea));
      end
      check($sformatf("busy_e%0d", e), 32'(busy_a), 32'(e < 6));
      check($sformatf("busy_b_e%0d", e), 32'(busy_b), 32'(e < 6));
      check($sformatf("done_e%0d", e), 32'(done_a), 32'(e == 6));
      check($sformatf("done_b_e%0d", e), 32'(done_b), 32'(e == 6));
    end
    start = 1'b0;
  endtask

  // monitor: pop and compare whenever a result is presented
  always @(negedge clk) begin
    if (done_a === 1'b1) begin
      dones_a++;
      if (qa.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL done_a_unexpected: got done with empty queue");
      end else begin
        check("out_a", out_a, qa.pop_front());
      end
    end
    if (done_b === 1'b1) begin
      dones_b++;
      if (qb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL done_b_unexpected: got done with empty queue");
      end else begin
        check("out_b", out_b, qb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    input_fc = '0;
    bias     = '0;
    for (int j = 0; j < IN; j++) rom[j] = '0;
    tick();
    tick();
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_out",  out_a, 32'd0);
    check("rst_addr", 32'(addr_a), 32'd0);
    reset = 1'b0;
    tick();

    // basic dot products
    xs = '{1, 2, 3, 4};
    for (int j = 0; j < IN; j++) begin
      ws[j][0] = 1;
      ws[j][1] = (j % 2 == 0) ? 1 : -1;
      ws[j][2] = 0;
      ws[j][3] = 2;
    end
    bs = '{0, 0, 0, 0};
    run_op(1'b1);
    check("plan_lane0", {24'd0, out_a[7:0]}, 32'd10);
    check("plan_lane1_relu", {24'd0, out_a[15:8]}, 32'd0);

    // saturation high and low
    xs = '{127, 127, 127, 127};
    for (int j = 0; j < IN; j++)
      for (int i = 0; i < ON; i++) ws[j][i] = 127;
    run_op(1'b0);
    check("sat_hi_a", out_a, 32'h7F7F7F7F);
    check("sat_hi_b", out_b, 32'h7F7F7F7F);
    for (int j = 0; j < IN; j++)
      for (int i = 0; i < ON; i++) ws[j][i] = -128;
    run_op(1'b0);
    check("sat_lo_b", out_b, 32'h80808080);
    check("sat_lo_relu_a", out_a, 32'h00000000);

    // fixed point 1.0 * 0.5 * 4 + 0.5
    xs = '{16, 16, 16, 16};
    for (int j = 0; j < IN; j++)
      for (int i = 0; i < ON; i++) ws[j][i] = 8;
    bs = '{8, 8, 8, 8};
    run_op(1'b0);
    check("fixpt_b", out_b, 32'h28282828);

    // reset mid-run aborts
    rand_all();
    drive_wb();
    drive_x();
    start = 1'b1;
    tick();
    push_exp();
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    void'(qa.pop_back());
    void'(qb.pop_back());
    n_acc--;
    check("abort_busy", 32'(busy_a), 32'd0);
    check("abort_done", 32'(done_a), 32'd0);
    check("abort_out_a", out_a, 32'd0);
    check("abort_out_b", out_b, 32'd0);
    check("abort_addr", 32'(addr_a), 32'd0);
    tick();
    rand_all();
    run_op(1'b0);

    // random operations
    for (int n = 0; n < 12; n++) begin
      rand_all();
      run_op(bit'($urandom_range(0, 1)));
    end

    // back-to-back with start held high
    rand_all();
    drive_wb();
    for (int c = 0; c <= 3 * (IN + 3); c++) begin
      for (int j = 0; j < IN; j++) xs[j] = rnd8();
      drive_x();
      start = 1'b1;
      tick();
      if (c % (IN + 3) == 0) push_exp();
    end
    start = 1'b0;

    for (int t = 0; t < 50 && (qa.size() + qb.size()) != 0; t++) tick();
    tick();
    check("queue_drained", 32'(qa.size() + qb.size()), 32'd0);
    check("done_count_a", 32'(dones_a), 32'(n_acc));
    check("done_count_b", 32'(dones_b), 32'(n_acc));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
